// File: rtl/rggen_axi4lite_pkg.sv
// rggen_axi4lite_pkg: shared bridge state encoding and AXI4-Lite response codes.
package rggen_axi4lite_pkg;
    typedef enum logic [1:0] {
        IDLE,
        BUS_ACCESS,
        WRITE_RESPONSE,
        READ_RESPONSE
    } rggen_axi4lite_bridge_state_e;
    localparam logic [1:0] RGGEN_AXI4LITE_OKAY   = 2'b00;
    localparam logic [1:0] RGGEN_AXI4LITE_SLVERR = 2'b10;
endpackage

// File: rtl/rggen_axi4lite_if.sv
// rggen_axi4lite_if: AXI4-Lite channel bundle (AW/W/B/AR/R) with master and slave views.
interface rggen_axi4lite_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                       awvalid;
    logic                       awready;
    logic [ADDRESS_WIDTH-1:0]   awaddr;
    logic [2:0]                 awprot;
    logic                       wvalid;
    logic                       wready;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [DATA_WIDTH/8-1:0]    wstrb;
    logic                       bvalid;
    logic                       bready;
    logic [1:0]                 bresp;
    logic                       arvalid;
    logic                       arready;
    logic [ADDRESS_WIDTH-1:0]   araddr;
    logic [2:0]                 arprot;
    logic                       rvalid;
    logic                       rready;
    logic [1:0]                 rresp;
    logic [DATA_WIDTH-1:0]      rdata;
    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );
    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );
endinterface

// File: rtl/rggen_axi4lite_slave_bridge.sv
// rggen_axi4lite_slave_bridge: turns one AXI4-Lite transaction at a time into a register bus access.
//   clk, rst          : clock, synchronous active-high reset
//   axi4lite_if       : AXI4-Lite slave side (AW/W/B/AR/R)
//   bus_valid/write/address/write_data/strobe : register bus command
//   bus_ready/read_data/error                 : register bus completion and response
module rggen_axi4lite_slave_bridge
    import rggen_axi4lite_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
)(
    input  logic                    clk,
    input  logic                    rst,
    rggen_axi4lite_if.slave         axi4lite_if,
    output logic                    bus_valid,
    output logic                    bus_write,
    output logic [ADDRESS_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0]   bus_write_data,
    output logic [DATA_WIDTH/8-1:0] bus_strobe,
    input  logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   bus_read_data,
    input  logic                    bus_error
);
    localparam int LSB = $clog2(DATA_WIDTH / 8);

    rggen_axi4lite_bridge_state_e state, state_next;
    logic [1:0]            resp;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  write_accept, read_accept, access_done;
    logic                  unused_inputs;

    // Protection bits and sub-word address bits carry no meaning for the register bus.
    assign unused_inputs = ^{axi4lite_if.awprot, axi4lite_if.arprot,
                             axi4lite_if.awaddr[LSB-1:0], axi4lite_if.araddr[LSB-1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // AW and W are taken together; a complete write request beats a pending read.
        write_accept = (state == IDLE) && axi4lite_if.awvalid && axi4lite_if.wvalid;
        read_accept  = (state == IDLE) && axi4lite_if.arvalid && !(axi4lite_if.awvalid && axi4lite_if.wvalid);
        access_done  = (state == BUS_ACCESS) && bus_ready;
        state_next   = state;
        case (state)
            IDLE:           state_next = (write_accept || read_accept) ? BUS_ACCESS : IDLE;
            BUS_ACCESS:     state_next = bus_ready ? (bus_write ? WRITE_RESPONSE : READ_RESPONSE) : BUS_ACCESS;
            WRITE_RESPONSE: state_next = axi4lite_if.bready ? IDLE : WRITE_RESPONSE;
            READ_RESPONSE:  state_next = axi4lite_if.rready ? IDLE : READ_RESPONSE;
            default:        state_next = IDLE;
        endcase
        axi4lite_if.awready = write_accept;
        axi4lite_if.wready  = write_accept;
        axi4lite_if.arready = read_accept;
        axi4lite_if.bvalid  = state == WRITE_RESPONSE;
        axi4lite_if.bresp   = resp;
        axi4lite_if.rvalid  = state == READ_RESPONSE;
        axi4lite_if.rresp   = resp;
        axi4lite_if.rdata   = rdata;
        bus_valid           = state == BUS_ACCESS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_write      <= 1'b0;
            bus_address    <= '0;
            bus_write_data <= '0;
            bus_strobe     <= '0;
        end else if (write_accept) begin
            bus_write      <= 1'b1;
            bus_address    <= {axi4lite_if.awaddr[ADDRESS_WIDTH-1:LSB], {LSB{1'b0}}};
            bus_write_data <= axi4lite_if.wdata;
            bus_strobe     <= axi4lite_if.wstrb;
        end else if (read_accept) begin
            bus_write      <= 1'b0;
            bus_address    <= {axi4lite_if.araddr[ADDRESS_WIDTH-1:LSB], {LSB{1'b0}}};
            bus_strobe     <= '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp  <= RGGEN_AXI4LITE_OKAY;
            rdata <= '0;
        end else if (access_done) begin
            resp  <= bus_error ? RGGEN_AXI4LITE_SLVERR : RGGEN_AXI4LITE_OKAY;
            if (!bus_write) rdata <= bus_read_data;
        end else if ((state == READ_RESPONSE) && axi4lite_if.rready) begin
            rdata <= '0;
        end
    end
endmodule

// File: tb/tb_rggen_axi4lite_slave_bridge.sv
// tb_rggen_axi4lite_slave_bridge: directed checks of the AXI4-Lite to register bus bridge.
module tb_rggen_axi4lite_slave_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        bus_valid, bus_write;
    logic [15:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_strobe;
    logic        bus_ready;
    logic [31:0] bus_read_data;
    logic        bus_error;
    int          compared = 0;
    int          mismatched = 0;

    rggen_axi4lite_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) axi_if ();

    rggen_axi4lite_slave_bridge #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .axi4lite_if    (axi_if),
        .bus_valid      (bus_valid),
        .bus_write      (bus_write),
        .bus_address    (bus_address),
        .bus_write_data (bus_write_data),
        .bus_strobe     (bus_strobe),
        .bus_ready      (bus_ready),
        .bus_read_data  (bus_read_data),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks follow 1 time unit later.
    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus_ready = 1'b0; bus_read_data = '0; bus_error = 1'b0;
        axi_if.awvalid = 0; axi_if.awaddr = '0; axi_if.awprot = '0;
        axi_if.wvalid = 0;  axi_if.wdata = '0;  axi_if.wstrb = '0;
        axi_if.bready = 0;
        axi_if.arvalid = 0; axi_if.araddr = '0; axi_if.arprot = '0;
        axi_if.rready = 0;
        step; step; #1;
        chk("rst_awready", axi_if.awready, 0);
        chk("rst_arready", axi_if.arready, 0);
        chk("rst_bvalid", axi_if.bvalid, 0);
        chk("rst_rvalid", axi_if.rvalid, 0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_write", bus_write, 0);
        chk("rst_bus_address", bus_address, 0);
        chk("rst_bus_strobe", bus_strobe, 0);
        chk("rst_rdata", axi_if.rdata, 0);
        chk("rst_bresp", axi_if.bresp, 0);

        // Zero-wait write, sub-word address gets aligned.
        step; rst = 0;
        axi_if.awvalid = 1; axi_if.awaddr = 16'h0013; axi_if.awprot = 3'h7;
        axi_if.wvalid = 1; axi_if.wdata = 32'hA5A5_1234; axi_if.wstrb = 4'b0011;
        axi_if.bready = 1; bus_ready = 1; #1;
        chk("w1_awready", axi_if.awready, 1);
        chk("w1_wready", axi_if.wready, 1);
        chk("w1_arready", axi_if.arready, 0);
        step; axi_if.awvalid = 0; axi_if.wvalid = 0; #1;
        chk("w1_bus_valid", bus_valid, 1);
        chk("w1_bus_address", bus_address, 16'h0010);
        chk("w1_bus_strobe", bus_strobe, 4'b0011);
        chk("w1_bus_write", bus_write, 1);
        chk("w1_bus_wdata", bus_write_data, 32'hA5A5_1234);
        chk("w1_bvalid_early", axi_if.bvalid, 0);
        step; #1;
        chk("w1_bvalid", axi_if.bvalid, 1);
        chk("w1_bresp", axi_if.bresp, 2'b00);
        chk("w1_bus_valid_off", bus_valid, 0);
        step; #1;
        chk("w1_bvalid_done", axi_if.bvalid, 0);
        chk("w1_awready_idle", axi_if.awready, 0);

        // Read with three wait cycles and delayed rready.
        axi_if.arvalid = 1; axi_if.araddr = 16'h0020; bus_ready = 0; axi_if.rready = 0; #1;
        chk("r1_arready", axi_if.arready, 1);
        step; axi_if.arvalid = 0; #1;
        chk("r1_bus_valid_1", bus_valid, 1);
        chk("r1_bus_strobe", bus_strobe, 4'hF);
        chk("r1_bus_write", bus_write, 0);
        chk("r1_bus_address", bus_address, 16'h0020);
        step; #1; chk("r1_bus_valid_2", bus_valid, 1);
        step; #1; chk("r1_bus_valid_3", bus_valid, 1);
        step; bus_ready = 1; bus_read_data = 32'hDEAD_BEEF; #1;
        chk("r1_bus_valid_4", bus_valid, 1);
        chk("r1_rvalid_early", axi_if.rvalid, 0);
        step; bus_ready = 0; #1;
        chk("r1_rvalid", axi_if.rvalid, 1);
        chk("r1_rdata", axi_if.rdata, 32'hDEAD_BEEF);
        chk("r1_rresp", axi_if.rresp, 2'b00);
        chk("r1_bus_valid_off", bus_valid, 0);
        step; #1;
        chk("r1_rvalid_hold", axi_if.rvalid, 1);
        chk("r1_rdata_hold", axi_if.rdata, 32'hDEAD_BEEF);
        step; axi_if.rready = 1; #1;
        chk("r1_rvalid_hold2", axi_if.rvalid, 1);
        step; axi_if.rready = 0; #1;
        chk("r1_rvalid_done", axi_if.rvalid, 0);
        chk("r1_rdata_clr", axi_if.rdata, 0);

        // Simultaneous write and read: write wins, read waits for the next idle cycle.
        axi_if.awvalid = 1; axi_if.awaddr = 16'h0040; axi_if.wvalid = 1;
        axi_if.wdata = 32'h0000_0001; axi_if.wstrb = 4'hF;
        axi_if.arvalid = 1; axi_if.araddr = 16'h0046; axi_if.bready = 0; bus_ready = 1; #1;
        chk("p_awready", axi_if.awready, 1);
        chk("p_arready", axi_if.arready, 0);
        step; axi_if.awvalid = 0; axi_if.wvalid = 0; #1;
        chk("p_arready_busy", axi_if.arready, 0);
        chk("p_bus_write", bus_write, 1);
        chk("p_bus_address", bus_address, 16'h0040);
        step; #1;
        chk("p_bvalid", axi_if.bvalid, 1);
        chk("p_arready_resp", axi_if.arready, 0);
        step; axi_if.bready = 1; #1;
        chk("p_bvalid_hold", axi_if.bvalid, 1);
        chk("p_arready_resp2", axi_if.arready, 0);
        step; axi_if.bready = 0; #1;
        chk("p_bvalid_done", axi_if.bvalid, 0);
        chk("p_arready_idle", axi_if.arready, 1);
        step; axi_if.arvalid = 0; #1;
        chk("p_rd_bus_write", bus_write, 0);
        chk("p_rd_bus_address", bus_address, 16'h0044);
        step; axi_if.rready = 1; #1;
        chk("p_rvalid", axi_if.rvalid, 1);
        step; axi_if.rready = 0; #1;
        chk("p_rvalid_done", axi_if.rvalid, 0);

        // AW without W for five cycles, then W with an all-zero strobe.
        axi_if.awvalid = 1; axi_if.awaddr = 16'h0008;
        for (int i = 0; i < 5; i++) begin
            #1; chk($sformatf("aw_only_awready_%0d", i), axi_if.awready, 0);
            chk($sformatf("aw_only_wready_%0d", i), axi_if.wready, 0);
            step;
        end
        axi_if.wvalid = 1; axi_if.wdata = 32'h1234_5678; axi_if.wstrb = 4'h0; #1;
        chk("aw_w_awready", axi_if.awready, 1);
        chk("aw_w_wready", axi_if.wready, 1);
        step; axi_if.awvalid = 0; axi_if.wvalid = 0; #1;
        chk("aw_w_awready_off", axi_if.awready, 0);
        chk("aw_w_strobe0", bus_strobe, 4'h0);
        chk("aw_w_address", bus_address, 16'h0008);
        step; axi_if.bready = 1; #1;
        chk("aw_w_bvalid", axi_if.bvalid, 1);
        step; axi_if.bready = 0;

        // Read with bus error, then a clean write.
        axi_if.arvalid = 1; axi_if.araddr = 16'h0004; bus_error = 1; bus_ready = 1;
        step; axi_if.arvalid = 0;
        step; #1;
        chk("err_rvalid", axi_if.rvalid, 1);
        chk("err_rresp", axi_if.rresp, 2'b10);
        axi_if.rready = 1;
        step; axi_if.rready = 0; bus_error = 0;
        axi_if.awvalid = 1; axi_if.awaddr = 16'h000C; axi_if.wvalid = 1; axi_if.wstrb = 4'hF;
        step; axi_if.awvalid = 0; axi_if.wvalid = 0;
        step; #1;
        chk("ok_bvalid", axi_if.bvalid, 1);
        chk("ok_bresp", axi_if.bresp, 2'b00);
        axi_if.bready = 1;
        step; axi_if.bready = 0;

        // Reset during BUS_ACCESS drops the transaction.
        axi_if.arvalid = 1; axi_if.araddr = 16'h0030; bus_ready = 0;
        step; axi_if.arvalid = 0; #1;
        chk("rm_bus_valid", bus_valid, 1);
        rst = 1;
        step; #1;
        chk("rm_bus_valid_off", bus_valid, 0);
        chk("rm_rvalid", axi_if.rvalid, 0);
        chk("rm_bvalid", axi_if.bvalid, 0);
        chk("rm_bus_address", bus_address, 0);
        rst = 0; bus_ready = 1;
        step; #1;
        chk("rm_rvalid_after", axi_if.rvalid, 0);
        chk("rm_bvalid_after", axi_if.bvalid, 0);
        axi_if.arvalid = 1; axi_if.araddr = 16'h0036; bus_read_data = 32'h1234_5678; #1;
        chk("rm_arready", axi_if.arready, 1);
        step; axi_if.arvalid = 0; #1;
        chk("rm_rd_address", bus_address, 16'h0034);
        step; #1;
        chk("rm_rd_rvalid", axi_if.rvalid, 1);
        chk("rm_rd_rdata", axi_if.rdata, 32'h1234_5678);
        axi_if.rready = 1;
        step; axi_if.rready = 0; #1;
        chk("rm_rd_done", axi_if.rvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
